// File: rtl/median_window_scan.sv
// median_window_scan: 3x3 binary median (majority) filter over a whole image.
// For every pixel the nine neighbourhood taps are read from a registered source
// memory, the in-range ones are counted, and the majority result is written out.
module median_window_scan #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] srcX,
    output logic [7:0] srcY,
    output logic       srcWrite,
    input  logic       srcData,
    output logic [7:0] dstX,
    output logic [7:0] dstY,
    output logic       dstData,
    output logic       dstWrite
);

    localparam int unsigned CW = 8;
    localparam int unsigned TW = 4;
    localparam int unsigned KW = 4;

    localparam logic [TW-1:0] LAST_TAP = TW'(8);
    localparam logic [KW-1:0] MAJORITY = KW'(5);
    localparam logic [CW-1:0] X_LAST   = CW'(IMWIDTH - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(IMHEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ACC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } stateT;

    stateT          state, stateN;
    logic [CW-1:0]  cx, cxN;
    logic [CW-1:0]  cy, cyN;
    logic [TW-1:0]  tap, tapN;
    logic [KW-1:0]  count, countN;
    logic [KW-1:0]  countAcc;
    logic           sampleHit;
    // curIn: in-range flag of the tap whose address is on srcX/srcY now.
    // pendIn: in-range flag of the tap whose data is on srcData now.
    logic           curIn;
    logic           pendIn, pendInN;
    logic           busyN, doneN;
    logic           dstWriteN, dstDataN;
    logic [CW-1:0]  dstXN, dstYN;
    logic           loadAddr;

    logic [CW-1:0]  addrX, addrY;
    logic           addrIn;

    // The source memory is never written by this block.
    assign srcWrite = 1'b0;

    // Next-state, counters and output values.
    always_comb begin
        stateN    = state;
        cxN       = cx;
        cyN       = cy;
        tapN      = tap;
        countN    = count;
        pendInN   = pendIn;
        busyN     = busy;
        doneN     = 1'b0;
        dstWriteN = 1'b0;
        dstXN     = dstX;
        dstYN     = dstY;
        dstDataN  = dstData;
        loadAddr  = 1'b0;

        sampleHit = pendIn & srcData;
        countAcc  = count + KW'(sampleHit);

        case (state)
            IDLE: begin
                if (start) begin
                    cxN      = '0;
                    cyN      = '0;
                    tapN     = '0;
                    countN   = '0;
                    pendInN  = 1'b0;
                    busyN    = 1'b1;
                    loadAddr = 1'b1;
                    stateN   = READ;
                end
            end
            READ: begin
                // Data of the previous tap arrives while this tap is addressed.
                countN  = countAcc;
                pendInN = curIn;
                if (tap == LAST_TAP) begin
                    stateN = ACC;
                end else begin
                    tapN     = tap + TW'(1);
                    loadAddr = 1'b1;
                end
            end
            ACC: begin
                countN    = countAcc;
                pendInN   = 1'b0;
                dstWriteN = 1'b1;
                dstXN     = cx;
                dstYN     = cy;
                dstDataN  = (countAcc >= MAJORITY);
                stateN    = WRITE;
            end
            WRITE: begin
                countN  = '0;
                tapN    = '0;
                pendInN = 1'b0;
                if ((cx == X_LAST) && (cy == Y_LAST)) begin
                    busyN  = 1'b0;
                    doneN  = 1'b1;
                    stateN = DONE;
                end else begin
                    if (cx == X_LAST) begin
                        cxN = '0;
                        cyN = cy + CW'(1);
                    end else begin
                        cxN = cx + CW'(1);
                    end
                    loadAddr = 1'b1;
                    stateN   = READ;
                end
            end
            DONE: begin
                stateN = IDLE;
            end
            default: begin
                stateN = IDLE;
            end
        endcase
    end

    // Clamped source address and in-range flag for the upcoming tap.
    always_comb begin
        int dx;
        int dy;
        int ox;
        int oy;

        case (tapN)
            TW'(0), TW'(3), TW'(6): dx = -1;
            TW'(2), TW'(5), TW'(8): dx = 1;
            default:                dx = 0;
        endcase
        case (tapN)
            TW'(0), TW'(1), TW'(2): dy = -1;
            TW'(6), TW'(7), TW'(8): dy = 1;
            default:                dy = 0;
        endcase

        ox = int'(cxN) + dx;
        oy = int'(cyN) + dy;

        addrIn = (ox >= 0) && (ox < IMWIDTH) && (oy >= 0) && (oy < IMHEIGHT);

        if (ox < 0) begin
            addrX = '0;
        end else if (ox > IMWIDTH - 1) begin
            addrX = X_LAST;
        end else begin
            addrX = CW'(ox);
        end

        if (oy < 0) begin
            addrY = '0;
        end else if (oy > IMHEIGHT - 1) begin
            addrY = Y_LAST;
        end else begin
            addrY = CW'(oy);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cx       <= '0;
            cy       <= '0;
            tap      <= '0;
            count    <= '0;
            pendIn   <= 1'b0;
            curIn    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            srcX     <= '0;
            srcY     <= '0;
            dstX     <= '0;
            dstY     <= '0;
            dstData  <= 1'b0;
            dstWrite <= 1'b0;
        end else begin
            state    <= stateN;
            cx       <= cxN;
            cy       <= cyN;
            tap      <= tapN;
            count    <= countN;
            pendIn   <= pendInN;
            busy     <= busyN;
            done     <= doneN;
            dstX     <= dstXN;
            dstY     <= dstYN;
            dstData  <= dstDataN;
            dstWrite <= dstWriteN;
            if (loadAddr) begin
                srcX  <= addrX;
                srcY  <= addrY;
                curIn <= addrIn;
            end
        end
    end

endmodule

// File: tb/tb_median_window_scan.sv
// Directed bench for median_window_scan on an 8x4 image.
module tb_median_window_scan;

    localparam int W = 8;
    localparam int H = 4;
    localparam int DONE_AT = W * H * 11 + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] srcX;
    logic [7:0] srcY;
    logic       srcWrite;
    logic       srcData;
    logic [7:0] dstX;
    logic [7:0] dstY;
    logic       dstData;
    logic       dstWrite;

    median_window_scan #(.IMWIDTH(W), .IMHEIGHT(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .srcX     (srcX),
        .srcY     (srcY),
        .srcWrite (srcWrite),
        .srcData  (srcData),
        .dstX     (dstX),
        .dstY     (dstY),
        .dstData  (dstData),
        .dstWrite (dstWrite)
    );

    always #5 clk = ~clk;

    logic srcImg [H][W];
    logic dstImg [H][W];

    int total = 0;
    int bad   = 0;

    int nWrites, orderErr, nDone, maxX, maxY, firstX, firstY, srcWrSeen;

    // Registered source memory: data valid the cycle after the address.
    always @(posedge clk) begin
        if (int'(srcX) < W && int'(srcY) < H)
            srcData <= srcImg[int'(srcY)][int'(srcX)];
        else
            srcData <= 1'b0;
    end

    // Destination capture and scan-order tracking.
    always @(negedge clk) begin
        if (srcWrite) srcWrSeen++;
        if (int'(srcX) > maxX) maxX = int'(srcX);
        if (int'(srcY) > maxY) maxY = int'(srcY);
        if (dstWrite) begin
            if (nWrites == 0) begin
                firstX = int'(dstX);
                firstY = int'(dstY);
            end
            if (int'(dstX) != nWrites % W || int'(dstY) != nWrites / W) orderErr++;
            if (int'(dstX) < W && int'(dstY) < H) dstImg[int'(dstY)][int'(dstX)] = dstData;
            nWrites++;
        end
        if (done) nDone++;
    end

    task automatic checkEq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clearMon();
        nWrites   = 0;
        orderErr  = 0;
        nDone     = 0;
        maxX      = 0;
        maxY      = 0;
        firstX    = -1;
        firstY    = -1;
        srcWrSeen = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                dstImg[y][x] = 1'b1;
    endtask

    task automatic setAll(input logic v);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                srcImg[y][x] = v;
    endtask

    function automatic logic refPix(input int x, input int y);
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    if (srcImg[y + dy][x + dx]) c++;
        return c >= 5;
    endfunction

    function automatic int imgDiff();
        int d = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (dstImg[y][x] != refPix(x, y)) d++;
        return d;
    endfunction

    function automatic int dstOnes();
        int c = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (dstImg[y][x]) c++;
        return c;
    endfunction

    // Start a scan (optionally re-pulse start at cycle restartAt) and wait for done.
    task automatic runScan(input int restartAt, output int doneAt, output int busyMid);
        int n;
        clearMon();
        doneAt  = -1;
        busyMid = -1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n <= 4 * DONE_AT) begin
            if (done) begin
                doneAt = n;
                break;
            end
            if (n == 5) busyMid = int'(busy);
            start = (n == restartAt);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int dAt, bMid;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        setAll(1'b0);
        clearMon();
        repeat (3) @(negedge clk);
        checkEq("rst_busy", int'(busy), 0);
        checkEq("rst_done", int'(done), 0);
        checkEq("rst_dstWrite", int'(dstWrite), 0);
        checkEq("rst_src_addr", int'({srcX, srcY}), 0);
        reset = 1'b0;
        @(negedge clk);

        // All-zero source.
        runScan(0, dAt, bMid);
        checkEq("zero_done_cycle", dAt, DONE_AT);
        checkEq("zero_busy_mid", bMid, 1);
        checkEq("zero_writes", nWrites, W * H);
        checkEq("zero_order", orderErr, 0);
        checkEq("zero_ones", dstOnes(), 0);
        checkEq("zero_done_pulses", nDone, 1);
        checkEq("zero_busy_after", int'(busy), 0);

        // Isolated pixel is removed.
        setAll(1'b0);
        srcImg[2][5] = 1'b1;
        runScan(0, dAt, bMid);
        checkEq("iso_pix", int'(dstImg[2][5]), 0);
        checkEq("iso_ones", dstOnes(), 0);

        // 3x3 block at x 3..5, y 0..2.
        setAll(1'b0);
        for (int y = 0; y <= 2; y++)
            for (int x = 3; x <= 5; x++)
                srcImg[y][x] = 1'b1;
        runScan(0, dAt, bMid);
        checkEq("blk_center_9", int'(dstImg[1][4]), 1);
        checkEq("blk_edge_6", int'(dstImg[1][3]), 1);
        checkEq("blk_corner_4", int'(dstImg[0][3]), 0);
        checkEq("blk_image", imgDiff(), 0);

        // All ones, with a second start pulse while busy.
        setAll(1'b1);
        runScan(100, dAt, bMid);
        checkEq("ones_corner00", int'(dstImg[0][0]), 0);
        checkEq("ones_top_edge", int'(dstImg[0][5]), 1);
        checkEq("ones_interior", int'(dstImg[2][5]), 1);
        checkEq("ones_corner_br", int'(dstImg[H-1][W-1]), 0);
        checkEq("ones_image", imgDiff(), 0);
        checkEq("ones_max_srcX", maxX, W - 1);
        checkEq("ones_max_srcY", maxY, H - 1);
        checkEq("ones_srcWrite", srcWrSeen, 0);
        checkEq("restart_writes", nWrites, W * H);
        checkEq("restart_done_pulses", nDone, 1);
        checkEq("restart_done_cycle", dAt, DONE_AT);

        // Reset in the middle of pixel (3,2), tap 4.
        begin
            int n;
            clearMon();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 1;
            while (n < 19 * 11 + 5) begin
                @(negedge clk);
                n++;
            end
            checkEq("mid_srcX", int'(srcX), 3);
            checkEq("mid_srcY", int'(srcY), 2);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            checkEq("abort_busy", int'(busy), 0);
            checkEq("abort_dstWrite", int'(dstWrite), 0);
            checkEq("abort_outs", int'({done, dstData, srcX, srcY, dstX, dstY}), 0);
            @(negedge clk);
            checkEq("abort_dstWrite_next", int'(dstWrite), 0);
            checkEq("abort_no_resume", int'(busy), 0);
        end
        runScan(0, dAt, bMid);
        checkEq("fresh_first_x", firstX, 0);
        checkEq("fresh_first_y", firstY, 0);
        checkEq("fresh_writes", nWrites, W * H);
        checkEq("fresh_done_cycle", dAt, DONE_AT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_window_scan.md
MEDIAN_WINDOW_SCAN -- requirements
Module: median_window_scan

Interface
REQ-001 SHALL have parameter IMWIDTH, default 240, image width in pixels.
REQ-002 SHALL have parameter IMHEIGHT, default 180, image height in pixels.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to filter the whole image.
REQ-006 SHALL have port busy  output  1  high from accepted start until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last destination write.
REQ-008 SHALL have port srcX  output  8  source memory column address.
REQ-009 SHALL have port srcY  output  8  source memory row address.
REQ-010 SHALL have port srcWrite  output  1  source memory write enable; tied 0.
REQ-011 SHALL have port srcData  input  1  source pixel; registered, valid the cycle after the address.
REQ-012 SHALL have port dstX  output  8  destination column address.
REQ-013 SHALL have port dstY  output  8  destination row address.
REQ-014 SHALL have port dstData  output  1  filtered pixel.
REQ-015 SHALL have port dstWrite  output  1  one-cycle destination write strobe.

Function
REQ-016 SHALL implement states IDLE, READ, ACC, WRITE and DONE.
REQ-017 IDLE: start=1 SHALL load cx=0, cy=0, tap=0 and count=0, set busy=1, and move to READ; start SHALL be ignored in all other states.
REQ-018 READ SHALL last exactly 9 cycles, one per tap t=0..8, in row-major order: dy=-1,0,+1 outer; dx=-1,0,+1 inner.
REQ-019 For tap t, srcX/srcY SHALL be (cx+dx, cy+dy) clamped to [0, IMWIDTH-1] and [0, IMHEIGHT-1].
REQ-020 A tap is out-of-range when cx+dx or cy+dy lies outside the image; an out-of-range tap SHALL contribute 0 regardless of srcData.
REQ-021 The sample for tap t SHALL be taken from srcData in the cycle after tap t's address cycle, so tap 0 is sampled in READ cycle 2 and tap 8 in ACC.
REQ-022 count SHALL be 4 bits unsigned and increment by 1 per in-range sample equal to 1; it never exceeds 9.
REQ-023 ACC SHALL last 1 cycle, capture tap 8, then move to WRITE.
REQ-024 In WRITE (1 cycle): dstWrite=1, dstX=cx, dstY=cy, and dstData=1 iff final count>=5 (binary median = majority of 9).
REQ-025 After WRITE, cx SHALL increment; when cx=IMWIDTH-1 it SHALL wrap to 0 and cy increments. count and tap SHALL clear, and the FSM returns to READ.
REQ-026 WRITE of (IMWIDTH-1, IMHEIGHT-1) SHALL go to DONE instead of READ.
REQ-027 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-028 Each pixel SHALL take exactly 11 cycles; a full image takes IMWIDTH*IMHEIGHT*11 cycles from the cycle after start to the last WRITE, inclusive.
REQ-029 dstWrite SHALL be 0 in every state except WRITE; dstX, dstY and dstData SHALL hold their last values outside WRITE.
REQ-030 srcWrite SHALL be 0 at all times.

Reset
REQ-031 reset=1 SHALL, on the next clock edge, force IDLE and clear busy, done, dstWrite, dstData, srcX, srcY, dstX, dstY, cx, cy, tap and count to 0.
REQ-032 Reset SHALL take priority over start and over any in-progress scan; no dstWrite SHALL occur in the reset cycle or in the cycle after it.
REQ-033 A scan aborted by reset SHALL NOT resume; a new start SHALL begin at (0,0).

Verification
REQ-034 All-zero source, IMWIDTH=8, IMHEIGHT=4: start -> 32 dstWrite pulses, all dstData=0; done exactly 352 cycles after start, plus 1.
REQ-035 Single 1 at (10,10), default size -> dst(10,10)=0 and every dstData=0 (isolated pixel removed).
REQ-036 3x3 block of 1s at x,y 49..51 -> dst(50,50)=1 (count 9), dst(49,50)=1 (count 6), dst(49,49)=0 (count 4).
REQ-037 All-ones source -> dst(0,0)=0 (4 in-range taps), dst(5,0)=1 (6 taps), dst(5,5)=1; srcX/srcY never exceed 239/179.
REQ-038 reset asserted mid-scan at pixel (3,2), READ tap 4 -> next cycle busy=0, dstWrite=0, all outputs 0; a fresh start writes (0,0) first.
REQ-039 start pulsed again while busy -> ignored; exactly IMWIDTH*IMHEIGHT writes and one done pulse.
